// File: rtl/plm_port_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port PLM bank among NCONSUMERS requesters.
// Latency: grant/bank drive combinational; read response PLM_LATENCY cycles after acceptance.
// Backpressure: req_ready grants at most one consumer per cycle; responses cannot be stalled.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   req_valid/req_wr       per-consumer request valid and write flag
//   req_addr/req_wdata     packed per-consumer address/write data (consumer i at slice i)
//   req_ready              one-hot (or zero) grant; a request is accepted on valid & ready
//   plm_en/wr/addr/wdata   bank port drive, all zero when nothing is granted
//   plm_rdata              bank read data, PLM_LATENCY cycles after a read access
//   rsp_valid/rsp_data     one-hot read-response strobe and shared read data
//   grant_count            per-consumer saturating accepted-request counters (optional)
// Optional feature: define PLM_ARB_STATS_EN to add the grant_count port and its counters.
module plm_port_arbiter #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int PLM_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NCONSUMERS-1:0]             req_valid,
  input  logic [NCONSUMERS-1:0]             req_wr,
  input  logic [NCONSUMERS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NCONSUMERS*VALUE_WIDTH-1:0] req_wdata,
  output logic [NCONSUMERS-1:0]             req_ready,
  output logic                              plm_en,
  output logic                              plm_wr,
  output logic [ADDR_WIDTH-1:0]             plm_addr,
  output logic [VALUE_WIDTH-1:0]            plm_wdata,
  input  logic [VALUE_WIDTH-1:0]            plm_rdata,
  output logic [NCONSUMERS-1:0]             rsp_valid,
  output logic [VALUE_WIDTH-1:0]            rsp_data
`ifdef PLM_ARB_STATS_EN
  ,
  output logic [NCONSUMERS*16-1:0]          grant_count
`endif
);

  localparam int ID_W = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

  logic [ID_W-1:0] pivot;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_id;

  // Search starting at the pivot, wrapping at NCONSUMERS (not 2^ID_W).
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NCONSUMERS; k++) begin
      idx = int'(pivot) + k;
      if (idx >= NCONSUMERS) idx = idx - NCONSUMERS;
      if (!gnt_any && req_valid[ID_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    // Nothing is granted while reset is held.
    if (reset) gnt_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    plm_en    = 1'b0;
    plm_wr    = 1'b0;
    plm_addr  = '0;
    plm_wdata = '0;
    if (gnt_any) begin
      req_ready[gnt_id] = 1'b1;
      plm_en            = 1'b1;
      plm_wr            = req_wr[gnt_id];
      plm_addr          = req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
      plm_wdata         = req_wdata[int'(gnt_id)*VALUE_WIDTH +: VALUE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pivot <= '0;
    end else if (gnt_any) begin
      pivot <= (int'(gnt_id) == NCONSUMERS - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  // Response pipe tracks which consumer owns each in-flight read.
  logic [PLM_LATENCY-1:0] pipe_vld;
  logic [ID_W-1:0]        pipe_id [PLM_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < PLM_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_vld[0] <= gnt_any && !req_wr[gnt_id];
      pipe_id[0]  <= gnt_id;
      for (int i = 1; i < PLM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  // Gated with reset so a read due in the reset cycle is also dropped.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (!reset && pipe_vld[PLM_LATENCY-1]) begin
      rsp_valid[pipe_id[PLM_LATENCY-1]] = 1'b1;
      rsp_data                          = plm_rdata;
    end
  end

`ifdef PLM_ARB_STATS_EN
  logic [15:0] cnt [NCONSUMERS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCONSUMERS; i++) cnt[i] <= '0;
    end else if (gnt_any && cnt[gnt_id] != 16'hFFFF) begin
      cnt[gnt_id] <= cnt[gnt_id] + 16'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NCONSUMERS; i++) grant_count[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_plm_port_arbiter.sv
// Testbench for plm_port_arbiter: scoreboard of expected read responses,
// reference rotation model for grants, behavioural PLM bank with fixed latency.
module tb_plm_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam int VW = 8;
  localparam int L  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*VW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic            plm_en, plm_wr;
  logic [AW-1:0]   plm_addr;
  logic [VW-1:0]   plm_wdata;
  logic [VW-1:0]   plm_rdata;
  logic [N-1:0]    rsp_valid;
  logic [VW-1:0]   rsp_data;
`ifdef PLM_ARB_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  always #5 clk = ~clk;

  plm_port_arbiter #(
    .ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(N), .PLM_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .plm_en(plm_en), .plm_wr(plm_wr), .plm_addr(plm_addr), .plm_wdata(plm_wdata),
    .plm_rdata(plm_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
`ifdef PLM_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural bank: contents preset on reset, read data after L cycles.
  logic [VW-1:0] mem [16];
  logic [VW-1:0] rd_pipe [L];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= VW'(i * 7 + 3);
    end else if (plm_en && plm_wr) begin
      mem[plm_addr] <= plm_wdata;
    end
    rd_pipe[0] <= mem[plm_addr];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign plm_rdata = rd_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            id;
    logic [VW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t          sb [$];
  logic [VW-1:0] exp_mem [16];
  int            m_pivot = 0;
  int            rsp_cnt [N] = '{0, 0, 0};
  int            rsp_total = 0;
  logic [VW-1:0] last_data = '0;
  int            last_id = -1;

  // Monitor: reference grant model plus scoreboard pop/compare.
  always @(negedge clk) begin : mon
    int           g;
    int           idx;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;
    logic [AW-1:0] a;
    rsp_t         e;
    g = -1;
    exp_rdy = '0;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_pivot + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    a = (g >= 0) ? req_addr[g*AW +: AW] : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("plm_en", 32'(plm_en), 32'(g >= 0));
    check("plm_wr", 32'(plm_wr), 32'((g >= 0) && req_wr[g]));
    check("plm_addr", 32'(plm_addr), 32'(a));
    check("plm_wdata", 32'(plm_wdata), (g >= 0) ? 32'(req_wdata[g*VW +: VW]) : 32'd0);

    exp_rsp = '0;
    if (!reset && sb.size() > 0 && sb[0].due == cyc) exp_rsp[sb[0].id] = 1'b1;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp != '0) begin
      e = sb.pop_front();
      check("rsp_data", 32'(rsp_data), 32'(e.data));
      rsp_cnt[e.id]++;
      rsp_total++;
      last_data = rsp_data;
      last_id = e.id;
    end else begin
      check("rsp_data_idle", 32'(rsp_data), 32'd0);
    end

    if (reset) begin
      m_pivot = 0;
      sb.delete();
      for (int i = 0; i < 16; i++) exp_mem[i] = VW'(i * 7 + 3);
    end else if (g >= 0) begin
      if (req_wr[g]) exp_mem[a] = req_wdata[g*VW +: VW];
      else sb.push_back('{g, exp_mem[a], cyc + L});
      m_pivot = (g + 1) % N;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] ad, input logic [VW-1:0] wd);
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = ad;
    req_wdata[i*VW +: VW] = wd;
  endtask

  int snap;
  int snap1;

  initial begin
    // Reset, then idle: monitor expects all outputs low.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();

    // All three consumers reading addrs 1,2,3: strict rotation.
    set_req(0, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b0, 4'd2, 8'h00);
    set_req(2, 1'b0, 4'd3, 8'h00);
    req_valid = 3'b111;
    repeat (6) tick();
    req_valid = '0;
    repeat (L + 1) tick();
    check("rot_rsp0", 32'(rsp_cnt[0]), 32'd2);
    check("rot_rsp1", 32'(rsp_cnt[1]), 32'd2);
    check("rot_rsp2", 32'(rsp_cnt[2]), 32'd2);

    // Consumer 1 writes A5 to addr 5, consumer 0 reads it back.
    snap1 = rsp_cnt[1];
    set_req(1, 1'b1, 4'd5, 8'hA5);
    req_valid = 3'b010;
    tick();
    set_req(0, 1'b0, 4'd5, 8'h00);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    repeat (L + 1) tick();
    check("wr_rd_data", 32'(last_data), 32'hA5);
    check("wr_rd_id", 32'(last_id), 32'd0);
    check("wr_no_rsp", 32'(rsp_cnt[1]), 32'(snap1));

    // Only consumer 2 valid: granted every cycle, pivot wraps to 0.
    snap = rsp_cnt[2];
    set_req(2, 1'b0, 4'd7, 8'h00);
    req_valid = 3'b100;
    repeat (4) tick();
    req_valid = 3'b111;
    set_req(0, 1'b0, 4'd4, 8'h00);
    set_req(1, 1'b0, 4'd6, 8'h00);
    @(negedge clk);
    check("pivot_wrap", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    repeat (L + 1) tick();
    check("solo_rsp2", 32'(rsp_cnt[2] - snap), 32'd4);

    // Two reads accepted, reset one cycle later: no responses for them.
    snap = rsp_total;
    req_valid = 3'b011;
    repeat (2) tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (L + 4) tick();
    check("rst_drop", 32'(rsp_total), 32'(snap));

    // Random mix of reads and writes.
    for (int c = 0; c < 150; c++) begin
      req_valid = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), VW'($urandom_range(0, 255)));
      tick();
    end
    req_valid = '0;
    repeat (L + 2) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

`ifdef PLM_ARB_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, 4'd2, 8'h00);
    req_valid = 3'b001;
    repeat (10) tick();
    req_valid = '0;
    repeat (L + 1) tick();
    check("stat0", 32'(grant_count[0 +: 16]), 32'd10);
    check("stat1", 32'(grant_count[16 +: 16]), 32'd0);
    check("stat2", 32'(grant_count[32 +: 16]), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("stat_rst", 32'(grant_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
